// File: rtl/traffic_multiphase_ctrl_pkg.sv
// Shared types and constants for the multiphase traffic controller family.
package traffic_pkg;

    typedef enum logic [1:0] {
        TL_GREEN  = 2'd0,
        TL_YELLOW = 2'd1,
        TL_ALLRED = 2'd2
    } tl_state_t;

    localparam int LED_G = 0;
    localparam int LED_Y = 1;
    localparam int LED_R = 2;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin search: first requester after active_phase, wrapping.
module traffic_rr_pick #(
    parameter  int N  = 4,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] active_phase,
    output logic [AW-1:0] next_phase,
    output logic          any_other
);

    // Walk from the farthest candidate down so the nearest one is written last.
    always_comb begin
        next_phase = active_phase;
        any_other  = 1'b0;
        for (int k = N - 1; k >= 1; k--) begin
            if (req[(int'(active_phase) + k) % N]) begin
                next_phase = AW'((int'(active_phase) + k) % N);
                any_other  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_multiphase_ctrl.sv
// N-phase traffic controller: sticky requests, min/max/gap-out green, yellow, all-red, round-robin.
// Optional pedestrian buttons and walk outputs are enabled with `define TRAFFIC_PED_EN.
module traffic_multiphase_ctrl
    import traffic_pkg::*;
#(
    parameter  int N_PHASES  = 4,
    parameter  int MIN_GREEN = 8,
    parameter  int MAX_GREEN = 30,
    parameter  int YELLOW_T  = 5,
    parameter  int ALLRED_T  = 2,
    localparam int AW        = $clog2(N_PHASES),
    localparam int TW        = $clog2(MAX_GREEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [N_PHASES-1:0]   sensor,
`ifdef TRAFFIC_PED_EN
    input  logic [N_PHASES-1:0]   ped_btn,
    output logic [N_PHASES-1:0]   walk,
`endif
    output logic [3*N_PHASES-1:0] led,
    output logic [AW-1:0]         active_phase,
    output tl_state_t             phase_state
);

    localparam logic [TW-1:0] T_MAX    = TW'(MAX_GREEN);
    localparam logic [TW-1:0] T_MAX_M1 = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_MIN    = TW'(MIN_GREEN);
    localparam logic [TW-1:0] T_MIN_M1 = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_YEL_M1 = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_AR_M1  = TW'(ALLRED_T - 1);

    tl_state_t             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d, timer_inc;
    logic [AW-1:0]         active_q, active_d;
    logic [AW-1:0]         next_q, next_d;
    logic [N_PHASES-1:0]   req_q, req_d, req_set, req_clr;
    logic [AW-1:0]         pick_phase;
    logic                  any_other;
    logic                  walk_active;
    logic                  gap_ok, max_ok;

    traffic_rr_pick #(.N(N_PHASES)) u_pick (
        .req          (req_q),
        .active_phase (active_q),
        .next_phase   (pick_phase),
        .any_other    (any_other)
    );

`ifdef TRAFFIC_PED_EN
    logic [N_PHASES-1:0] ped_q, ped_d, ped_set;
    logic                walk_q, walk_d;

    assign walk_active = walk_q && (state_q == TL_GREEN) && (timer_q < T_MIN);

    // The walk flag is decided once, at the moment the phase enters green.
    always_comb begin
        ped_set = ped_btn;
        if (state_q == TL_GREEN) ped_set[active_q] = 1'b0;
        ped_d  = (ped_q | ped_set) & ~req_clr;
        walk_d = walk_q;
        if (req_clr != '0) walk_d = ped_q[next_q];
    end

    always_comb begin
        walk = '0;
        walk[active_q] = walk_active;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_q  <= '0;
            walk_q <= 1'b0;
        end else begin
            ped_q  <= ped_d;
            walk_q <= walk_d;
        end
    end
`else
    assign walk_active = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        active_d  = active_q;
        next_d    = next_q;
        req_clr   = '0;
        gap_ok    = 1'b0;
        max_ok    = 1'b0;
        timer_inc = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;

        req_set = sensor;
`ifdef TRAFFIC_PED_EN
        req_set = req_set | ped_btn;
`endif
        if (state_q == TL_GREEN) req_set[active_q] = 1'b0;

        if (tick) begin
            case (state_q)
                TL_GREEN: begin
                    gap_ok = (timer_q >= T_MIN_M1) && !sensor[active_q] && !walk_active;
                    max_ok = (timer_q >= T_MAX_M1);
                    if (any_other && (gap_ok || max_ok)) begin
                        state_d = TL_YELLOW;
                        timer_d = '0;
                        next_d  = pick_phase;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                TL_YELLOW: begin
                    if (timer_q == T_YEL_M1) begin
                        state_d = TL_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                TL_ALLRED: begin
                    if (timer_q == T_AR_M1) begin
                        state_d          = TL_GREEN;
                        timer_d          = '0;
                        active_d         = next_q;
                        req_clr[next_q]  = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    state_d = TL_GREEN;
                    timer_d = '0;
                end
            endcase
        end

        // Clear beats a simultaneous set for the phase entering green.
        req_d = (req_q | req_set) & ~req_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TL_GREEN;
            timer_q  <= '0;
            active_q <= '0;
            next_q   <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            next_q   <= next_d;
            req_q    <= req_d;
        end
    end

    always_comb begin
        led = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            if (AW'(i) == active_q && state_q == TL_GREEN)       led[3*i +: 3] = GRN;
            else if (AW'(i) == active_q && state_q == TL_YELLOW) led[3*i +: 3] = YEL;
            else                                                 led[3*i +: 3] = RED;
        end
    end

    assign active_phase = active_q;
    assign phase_state  = state_q;

endmodule

// File: tb/tb_traffic_multiphase_ctrl.sv
// Bench for traffic_multiphase_ctrl: directed tables, scenario sequences and a random run vs a reference model.
module tb_traffic_multiphase_ctrl;
    import traffic_pkg::*;

    localparam int N     = 4;
    localparam int MIN_G = 8;
    localparam int MAX_G = 30;
    localparam int YEL_T = 5;
    localparam int AR_T  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic [N-1:0]   sensor;
    logic [3*N-1:0] led;
    logic [1:0]     active_phase;
    tl_state_t      phase_state;
`ifdef TRAFFIC_PED_EN
    logic [N-1:0]   ped_btn = '0;
    logic [N-1:0]   walk;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_multiphase_ctrl #(
        .N_PHASES(N), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL_T), .ALLRED_T(AR_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .sensor       (sensor),
`ifdef TRAFFIC_PED_EN
        .ped_btn      (ped_btn),
        .walk         (walk),
`endif
        .led          (led),
        .active_phase (active_phase),
        .phase_state  (phase_state)
    );

    // Reference model: 0=green 1=yellow 2=all-red, elapsed ticks in the current interval.
    int     m_state, m_act, m_next, m_elapsed;
    bit [N-1:0] m_req;

    function automatic void model_reset();
        m_state = 0; m_act = 0; m_next = 0; m_elapsed = 0; m_req = '0;
    endfunction

    function automatic void model_step(input bit tk, input bit [N-1:0] s);
        bit [N-1:0] nr;
        bit other;
        bit found;
        nr = m_req;
        for (int i = 0; i < N; i++)
            if (s[i] && !(m_state == 0 && i == m_act)) nr[i] = 1'b1;
        if (tk) begin
            if (m_state == 0) begin
                other = 1'b0;
                for (int i = 0; i < N; i++) if (i != m_act && m_req[i]) other = 1'b1;
                if (other && ((m_elapsed >= MIN_G - 1 && !s[m_act]) || m_elapsed >= MAX_G - 1)) begin
                    found = 1'b0;
                    for (int k = 1; k < N; k++)
                        if (!found && m_req[(m_act + k) % N]) begin
                            m_next = (m_act + k) % N;
                            found  = 1'b1;
                        end
                    m_state = 1; m_elapsed = 0;
                end else if (m_elapsed < MAX_G) begin
                    m_elapsed++;
                end
            end else if (m_state == 1) begin
                if (m_elapsed == YEL_T - 1) begin m_state = 2; m_elapsed = 0; end
                else m_elapsed++;
            end else begin
                if (m_elapsed == AR_T - 1) begin
                    m_state = 0; m_elapsed = 0; m_act = m_next; nr[m_act] = 1'b0;
                end else m_elapsed++;
            end
        end
        m_req = nr;
    endfunction

    function automatic logic [3*N-1:0] exp_led(input int st, input int act);
        logic [3*N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (i == act && st == 0)      r[3*i +: 3] = 3'b001;
            else if (i == act && st == 1) r[3*i +: 3] = 3'b010;
            else                          r[3*i +: 3] = 3'b100;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int st, input int act);
        check({tag, " led"}, 32'(led), 32'(exp_led(st, act)));
        check({tag, " active_phase"}, 32'(active_phase), act);
        check({tag, " phase_state"}, 32'(phase_state), st);
    endtask

    task automatic run_cycle(input string tag);
        check_outputs(tag, m_state, m_act);
        model_step(tick, sensor);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b1; sensor = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic         tick;
        logic [N-1:0] sensor;
        int           exp_act;
        int           exp_state;
    } vec_t;

    vec_t vecs[40];
    int   nvec;

    // Expected timeline for a single phase change out of phase 0 after green_len green cycles.
    task automatic fill_change(input int green_len, input int target,
                               input logic [N-1:0] pulse, input logic [N-1:0] hold);
        nvec = green_len + YEL_T + AR_T + 2;
        for (int k = 0; k < nvec; k++) begin
            vecs[k].tick   = 1'b1;
            vecs[k].sensor = hold | ((k == 0) ? pulse : '0);
            if (k < green_len)                     vecs[k].exp_state = 0;
            else if (k < green_len + YEL_T)        vecs[k].exp_state = 1;
            else if (k < green_len + YEL_T + AR_T) vecs[k].exp_state = 2;
            else                                   vecs[k].exp_state = 0;
            vecs[k].exp_act = (k < green_len + YEL_T + AR_T) ? 0 : target;
        end
    endtask

    task automatic apply_table(input string tag);
        for (int k = 0; k < nvec; k++) begin
            tick   = vecs[k].tick;
            sensor = vecs[k].sensor;
            check_outputs($sformatf("%s c%0d", tag, k), vecs[k].exp_state, vecs[k].exp_act);
            @(posedge clk);
            #1;
        end
    endtask

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    initial begin
        int last_green;
        int yel_ticked;
        int yel_total;
        bit found;
        rst = 1'b1; tick = 1'b0; sensor = '0;

        // Reset state and rest in green.
        do_reset();
        check("reset led", 32'(led), 32'(12'b100_100_100_001));
        for (int c = 0; c < 100; c++) run_cycle("rest");

        // Gap-out to phase 2.
        do_reset();
        fill_change(MIN_G, 2, 4'b0100, 4'b0000);
        apply_table("gapout");

        // Max-out with phase 0 sensor held.
        do_reset();
        fill_change(MAX_G, 1, 4'b0010, 4'b0001);
        apply_table("maxout");

        // Round-robin wrap: from phase 2 with requests on 0 and 3.
        do_reset();
        exp_q = {2'd2, 2'd3, 2'd0};
        got_q.delete();
        last_green = 0;
        for (int c = 0; c < 100; c++) begin
            sensor = (c == 0) ? 4'b0100 : ((c == 16 || c == 17) ? 4'b1001 : 4'b0000);
            if (phase_state == TL_GREEN && int'(active_phase) != last_green) begin
                last_green = int'(active_phase);
                got_q.push_back(active_phase);
            end
            run_cycle("rr");
        end
        check("rr order count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rr order %0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Tick frozen during yellow.
        do_reset();
        yel_ticked = 0; yel_total = 0;
        for (int c = 0; c < 40; c++) begin
            sensor = (c == 0) ? 4'b0010 : 4'b0000;
            tick   = (c >= 9 && c <= 18) ? 1'b0 : 1'b1;
            if (phase_state == TL_YELLOW) begin
                yel_total++;
                if (tick) yel_ticked++;
            end
            run_cycle("freeze");
        end
        check("yellow ticked cycles", yel_ticked, YEL_T);
        check("yellow total cycles", yel_total, YEL_T + 10);

        // Reset during all-red with a pending request for phase 1.
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            sensor = (c == 0) ? 4'b0010 : 4'b0000;
            if (phase_state == TL_ALLRED) found = 1'b1;
            else run_cycle("to allred");
        end
        check("reached allred", 32'(found), 1);
        rst = 1'b1;
        #1;
        check("async rst led", 32'(led), 32'(12'b100_100_100_001));
        check("async rst active", 32'(active_phase), 0);
        check("async rst state", 32'(phase_state), 32'(TL_GREEN));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) run_cycle("post rst");

        // Random stimulus against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) sensor[i] = ($urandom_range(0, 15) == 0);
            tick = ($urandom_range(0, 3) != 0);
            run_cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_multiphase_ctrl.md
Name: traffic_multiphase_ctrl

Overview:
- Parametrised N-phase traffic-light controller for intersections with more than two conflicting approaches.
- Generalises the two-road controller:
  - N phases, each with its own vehicle sensor.
  - Sticky request latching.
  - Min-green, max-green and gap-out timing.
  - All-red clearance interval.
  - Round-robin service.
- Timing advances on an external tick strobe from the shared prescaler, so durations are expressed in ticks.

Parameters:
- N_PHASES, 4, number of phases/approaches (>=2).
- MIN_GREEN, 8, minimum green duration in ticks (>=1).
- MAX_GREEN, 30, maximum green duration in ticks while another phase is requesting (>=MIN_GREEN).
- YELLOW_T, 5, yellow duration in ticks (>=1).
- ALLRED_T, 2, all-red clearance duration in ticks (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  timing strobe, one clk wide; all timers advance only when tick=1
- sensor  in  N_PHASES  vehicle present on phase i (level or pulse)
- led  out  3*N_PHASES  per phase i: led[3i+2]=red, led[3i+1]=yellow, led[3i]=green
- active_phase  out  $clog2(N_PHASES)  phase currently owning green/yellow
- phase_state  out  2  current tl_state_t (GREEN/YELLOW/ALLRED)

Behaviour:
- Reset state: GREEN, active_phase=0, timer=0, req=0, next_phase=0.
  - led: phase 0 = 001, all others = 100. For N=4: 12'b100_100_100_001.
- Outputs are Moore, decoded from registers:
  - GREEN: active phase shows 001.
  - YELLOW: active phase shows 010.
  - ALLRED: every phase shows 100.
  - Non-active phases always show 100.
- Request latch req[i]:
  - Set on any cycle with sensor[i]=1, except phase i while it is in GREEN.
  - Cleared on the cycle phase i enters GREEN; clear wins over a simultaneous set.
  - Sensor activity on the active phase during its YELLOW/ALLRED sets its req, so it is served next round.
- req_other = |req excluding active_phase.
- Timer:
  - Width $clog2(MAX_GREEN+1).
  - Increments on tick and saturates at MAX_GREEN.
  - Cleared to 0 on every state change.
- GREEN transitions, evaluated only when tick=1, using the timer value before increment:
  - Gap-out: timer>=MIN_GREEN-1, sensor[active]=0, req_other=1 -> YELLOW.
  - Max-out: timer>=MAX_GREEN-1, req_other=1 -> YELLOW, regardless of sensor[active].
  - req_other=0 -> remain GREEN indefinitely (rest in green).
  - On leaving GREEN, latch next_phase = first i with req[i]=1 searching active_phase+1, +2, ... with wrap modulo N_PHASES.
- YELLOW: on tick with timer==YELLOW_T-1 -> ALLRED. Lasts exactly YELLOW_T ticks.
- ALLRED:
  - On tick with timer==ALLRED_T-1 -> GREEN.
  - active_phase <= next_phase; req[next_phase] cleared.
  - Lasts exactly ALLRED_T ticks.
- tick=0: timer and state frozen; req latching continues.
- Reset asserted mid-operation: immediate return to the reset state; pending requests are discarded.
- Latency with tick tied high: minimum phase-change time = MIN_GREEN+YELLOW_T+ALLRED_T clk cycles.

Optional Feature:
- Macro TRAFFIC_PED_EN.
- When defined:
  - Add inputs ped_btn[N_PHASES] and outputs walk[N_PHASES].
  - ped_btn[i] sets req[i], using the same rules as sensor.
  - Each phase has a sticky ped_pend[i], cleared when phase i enters GREEN.
  - If ped_pend[i] was set when phase i entered GREEN, walk[i]=1 for the first MIN_GREEN ticks of that green, and gap-out is suppressed until walk ends.
- When undefined: no ped ports; behaviour exactly as above.

Decomposition:
- Package traffic_pkg:
  - tl_state_t enum {TL_GREEN=2'd0, TL_YELLOW=2'd1, TL_ALLRED=2'd2}.
  - LED bit-position constants LED_G=0, LED_Y=1, LED_R=2.
  - Encoded colour constants: RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module traffic_rr_pick: combinational round-robin search.
  - Inputs: req, active_phase.
  - Outputs: next_phase, any_other.
  - Reused by future arbitrated blocks.

Test Plan:
- Reset, tick=1, N=4, defaults -> led=12'b100_100_100_001, active_phase=0, phase_state=GREEN. Holds 100 cycles with sensor=0 (rest in green).
- 1-cycle pulse sensor[2] at cycle 0, sensor[0]=0 -> phase 0 green cycles 0-7, yellow 8-12, all-red 13-14, phase 2 green from cycle 15. req[2] cleared at cycle 15.
- sensor[0] held 1, sensor[1] pulsed at cycle 0 -> phase 0 green exactly 30 cycles (max-out), then yellow 5, all-red 2, phase 1 green.
- Phase 2 green, req[0] and req[3] set, gap-out -> next_phase=3 (round-robin wrap). After phase 3, phase 0 served.
- tick=0 for 10 cycles during YELLOW -> led frozen at yellow. Yellow still totals 5 ticked cycles once tick resumes.
- rst pulse mid-ALLRED with req[1]=1 -> next cycle led=12'b100_100_100_001, req=0, active_phase=0.
